// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: round-robin front end and 2-stage pipeline
// sharing one external 8x8 approximate multiplier.
module approx_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  output logic [7:0]           mul_x,
  output logic [7:0]           mul_y,
  input  logic [15:0]          mul_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_z,
  output logic [CNT_W-1:0]     op_count
);

  logic            r_s1_valid;
  logic [ID_W-1:0] r_s1_id;
  logic [7:0]      r_s1_x;
  logic [7:0]      r_s1_y;
  logic            r_s2_valid;
  logic [ID_W-1:0] r_s2_id;
  logic [15:0]     r_s2_z;
  logic [ID_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic            w_adv;
  logic            w_accept;
  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [7:0]      w_gx;
  logic [7:0]      w_gy;

  assign w_adv    = !r_s2_valid || rsp_ready;
  assign w_accept = !r_s1_valid || w_adv;

  // first asserted index at or after the pointer, wrapping
  always_comb begin
    int idx_i;
    logic [ID_W-1:0] idx;
    idx_i     = 0;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_i = int'(r_ptr) + k;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      idx = ID_W'(idx_i);
      if (!w_gnt_vld && req_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = idx;
      end
    end
  end

  always_comb begin
    w_gx = '0;
    w_gy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_gx = req_x[8*i +: 8];
        w_gy = req_y[8*i +: 8];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ-1)) ?
                     '0 : w_gnt + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (rst_n && w_accept && w_gnt_vld)
      req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_z     <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_id    <= r_s1_id;
        if (r_s1_valid) r_s2_z <= mul_z;
      end
      if (w_accept) begin
        r_s1_valid <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_s1_id <= w_gnt;
          r_s1_x  <= w_gx;
          r_s1_y  <= w_gy;
          r_ptr   <= w_ptr_nxt;
        end
      end
      if (r_s2_valid && rsp_ready && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // idle operands forced to zero to keep the multiplier quiet
  assign mul_x     = r_s1_valid ? r_s1_x : '0;
  assign mul_y     = r_s1_valid ? r_s1_y : '0;
  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign rsp_z     = r_s2_z;
  assign op_count  = r_cnt;

endmodule
